// File: rtl/board_mem_ctrl.sv
// Board-state memory owner: a 256x4 single-port array that gives the renderer absolute priority.
// Clear writes, game-logic writes and game-logic reads share the cycles the renderer leaves free.
module board_mem_ctrl #(
    parameter int unsigned CELLS  = 256,
    parameter int unsigned DATA_W = 4
) (
    input  logic              i_pclk,
    input  logic              i_rst_n,
    input  logic              i_rd_en,
    input  logic [7:0]        i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    input  logic              i_wr_req,
    input  logic [7:0]        i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_ack,
    input  logic              i_lr_req,
    input  logic [7:0]        i_lr_addr,
    output logic [DATA_W-1:0] o_lr_data,
    output logic              o_lr_valid,
    input  logic              i_clr,
    input  logic [DATA_W-1:0] i_clr_value,
    output logic              o_busy,
    output logic              o_clr_done
);

    typedef enum logic [1:0] {StIdle, StClear, StDone} state_e;

    state_e            state_q;
    logic [7:0]        cnt_q;
    logic [DATA_W-1:0] fill_q;
    logic              blackout_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] lr_data_q;
    logic              wr_ack_q;
    logic              lr_valid_q;
    logic              clr_done_q;

    logic [DATA_W-1:0] mem [CELLS];

    logic              gl_free;
    logic              wr_grant;
    logic              lr_grant;
    logic              clr_we;
    logic              mem_we;
    logic [7:0]        mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    always_comb begin
        // A clear request in the same idle cycle takes precedence over game-logic traffic.
        gl_free   = !i_rd_en && (state_q == StIdle) && !blackout_q && !i_clr;
        wr_grant  = gl_free && i_wr_req;
        lr_grant  = gl_free && i_lr_req && !i_wr_req;
        clr_we    = !i_rd_en && (state_q == StClear);
        mem_we    = i_rst_n && (clr_we || wr_grant);
        mem_waddr = clr_we ? cnt_q : i_wr_addr;
        mem_wdata = clr_we ? fill_q : i_wr_data;
    end

    // Array is deliberately not reset; a reset cycle suppresses any write.
    always_ff @(posedge i_pclk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge i_pclk) begin
        if (!i_rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= 8'd0;
            fill_q     <= '0;
            blackout_q <= 1'b0;
            rd_data_q  <= '0;
            lr_data_q  <= '0;
            wr_ack_q   <= 1'b0;
            lr_valid_q <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            blackout_q <= wr_grant || lr_grant;
            wr_ack_q   <= wr_grant;
            lr_valid_q <= lr_grant;
            clr_done_q <= (state_q == StDone);
            if (i_rd_en) begin
                rd_data_q <= mem[i_rd_addr];
            end
            if (lr_grant) begin
                lr_data_q <= mem[i_lr_addr];
            end
            unique case (state_q)
                StIdle: begin
                    if (i_clr) begin
                        fill_q  <= i_clr_value;
                        cnt_q   <= 8'd0;
                        state_q <= StClear;
                    end
                end
                StClear: begin
                    if (!i_rd_en) begin
                        cnt_q <= cnt_q + 8'd1;
                        if (cnt_q == 8'(CELLS - 1)) begin
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign o_rd_data  = rd_data_q;
    assign o_lr_data  = lr_data_q;
    assign o_wr_ack   = wr_ack_q;
    assign o_lr_valid = lr_valid_q;
    assign o_clr_done = clr_done_q;
    assign o_busy     = (state_q != StIdle);

endmodule
